// File: rtl/boot_copy_ctrl_pkg.sv
// Shared types and width helpers for the boot copy sequencer.
package boot_copy_ctrl_pkg;

    typedef enum logic [2:0] {
        StStart,
        StRdReq,
        StRdWait,
        StWrReq,
        StHold,
        StRun
    } state_e;

    // Word counter must hold 0..BOOT_WORDS without wrapping; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned words);
        return (words == 0) ? 1 : int'($clog2(words + 1));
    endfunction

    function automatic int unsigned hold_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : int'($clog2(cycles + 1));
    endfunction

endpackage

// File: rtl/iob_reg_re.sv
// Register with async reset, clock enable, sync reset and load enable.
module iob_reg_re #(
    parameter int unsigned        DATA_W  = 32,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_o <= RST_VAL;
        end else if (cke_i) begin
            if (rst_i) begin
                data_o <= RST_VAL;
            end else if (en_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/boot_copy_ctrl.sv
// Copies the boot image from ROM to SRAM word by word, holds the CPU in reset
// for a fixed time afterwards, then releases it until a restart is requested.
module boot_copy_ctrl
    import boot_copy_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ROM_ADDR_W  = 12,
    parameter int unsigned SRAM_ADDR_W = 16,
    parameter int unsigned BOOT_WORDS  = 1024,
    parameter int unsigned SRAM_BASE   = 0,
    parameter int unsigned RESET_HOLD  = 100
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   cke_i,
    input  logic                   restart_i,
    output logic                   rom_avalid_o,
    output logic [ROM_ADDR_W-1:0]  rom_addr_o,
    input  logic                   rom_ready_i,
    input  logic                   rom_rvalid_i,
    input  logic [DATA_W-1:0]      rom_rdata_i,
    output logic                   sram_avalid_o,
    output logic [SRAM_ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0]      sram_wdata_o,
    output logic [DATA_W/8-1:0]    sram_wstrb_o,
    input  logic                   sram_ready_i,
    output logic                   cpu_reset_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned CNT_W  = cnt_width(BOOT_WORDS);
    localparam int unsigned HOLD_W = hold_width(RESET_HOLD);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'((BOOT_WORDS == 0) ? 0 : BOOT_WORDS - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'((RESET_HOLD == 0) ? 0 : RESET_HOLD - 1);
    // A zero hold skips HOLD entirely so the release timing stays 1 + 3*N + RESET_HOLD.
    localparam state_e AFTER_COPY = (RESET_HOLD == 0) ? StRun : StHold;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] data_q;
    logic              capture_en;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= StStart;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            StStart: begin
                cnt_d   = '0;
                hold_d  = '0;
                state_d = (BOOT_WORDS == 0) ? AFTER_COPY : StRdReq;
            end
            StRdReq: begin
                if (rom_ready_i) state_d = StRdWait;
            end
            StRdWait: begin
                if (rom_rvalid_i) state_d = StWrReq;
            end
            StWrReq: begin
                if (sram_ready_i) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = AFTER_COPY;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = StRdReq;
                    end
                end
            end
            StHold: begin
                if (hold_q == LAST_HOLD) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            StRun: begin
                if (restart_i) state_d = StStart;
            end
            default: state_d = StStart;
        endcase
    end

    assign capture_en = (state_q == StRdWait) && rom_rvalid_i;

    iob_reg_re #(
        .DATA_W  (DATA_W),
        .RST_VAL ('0)
    ) u_data_reg (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .rst_i    (1'b0),
        .en_i     (capture_en),
        .data_i   (rom_rdata_i),
        .data_o   (data_q)
    );

    assign rom_avalid_o  = (state_q == StRdReq);
    assign rom_addr_o    = ROM_ADDR_W'(32'(cnt_q) * BYTES);
    assign sram_avalid_o = (state_q == StWrReq);
    assign sram_addr_o   = SRAM_ADDR_W'(SRAM_BASE + 32'(cnt_q) * BYTES);
    assign sram_wdata_o  = data_q;
    assign sram_wstrb_o  = '1;
    assign cpu_reset_o   = (state_q != StRun);
    assign done_o        = (state_q == StRun);
    assign busy_o        = (state_q == StRdReq) || (state_q == StRdWait) ||
                           (state_q == StWrReq) || (state_q == StHold);

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Directed bench for boot_copy_ctrl with a ROM/SRAM model and write scoreboard.
module tb_boot_copy_ctrl;

    localparam int NW   = 4;
    localparam int HOLD = 5;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        arst_n, cke, restart;
    logic        rom_avalid, rom_ready, rom_rvalid;
    logic [11:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        sram_avalid, sram_ready;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wstrb;
    logic        cpu_reset, busy, done;

    logic        z_rom_avalid, z_sram_avalid, z_cpu_reset, z_busy, z_done;
    logic [11:0] z_rom_addr;
    logic [15:0] z_sram_addr;
    logic [31:0] z_sram_wdata;
    logic [3:0]  z_sram_wstrb;

    always #5 clk = ~clk;

    boot_copy_ctrl #(
        .DATA_W(32), .ROM_ADDR_W(12), .SRAM_ADDR_W(16),
        .BOOT_WORDS(NW), .SRAM_BASE(0), .RESET_HOLD(HOLD)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .restart_i(restart),
        .rom_avalid_o(rom_avalid), .rom_addr_o(rom_addr), .rom_ready_i(rom_ready),
        .rom_rvalid_i(rom_rvalid), .rom_rdata_i(rom_rdata),
        .sram_avalid_o(sram_avalid), .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
        .sram_wstrb_o(sram_wstrb), .sram_ready_i(sram_ready),
        .cpu_reset_o(cpu_reset), .busy_o(busy), .done_o(done)
    );

    boot_copy_ctrl #(
        .DATA_W(32), .ROM_ADDR_W(12), .SRAM_ADDR_W(16),
        .BOOT_WORDS(0), .SRAM_BASE(0), .RESET_HOLD(HOLD)
    ) dut_zero (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .restart_i(restart),
        .rom_avalid_o(z_rom_avalid), .rom_addr_o(z_rom_addr), .rom_ready_i(1'b1),
        .rom_rvalid_i(1'b1), .rom_rdata_i(32'h0),
        .sram_avalid_o(z_sram_avalid), .sram_addr_o(z_sram_addr),
        .sram_wdata_o(z_sram_wdata), .sram_wstrb_o(z_sram_wstrb), .sram_ready_i(1'b1),
        .cpu_reset_o(z_cpu_reset), .busy_o(z_busy), .done_o(z_done)
    );

    logic [31:0] image [NW] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [31:0] mem   [NW];
    wr_t         exp_q [$];

    int n_cmp = 0, n_fail = 0;
    int cyc, z_fall, z_req, writes;
    int max_stall = 0, rv_delay = 1;
    int rom_stall, sram_stall, rv_left, rv_idx, rd_idx;
    bit rom_wait, sram_wait, rv_pend, prev_rom_hold, prev_sram_hold;
    bit cke_next = 1'b1;
    logic [11:0] prev_rom_addr;
    logic [15:0] prev_sram_addr;
    logic [31:0] prev_sram_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_models();
        exp_q.delete();
        rv_pend = 0; rom_wait = 0; sram_wait = 0;
        prev_rom_hold = 0; prev_sram_hold = 0;
        rd_idx = 0; writes = 0; z_fall = -1;
        for (int i = 0; i < NW; i++) mem[i] = 32'h0;
    endtask

    // One cycle: sample outputs at the falling edge, then drive this cycle's inputs.
    task automatic step();
        wr_t e;
        int  idx;
        @(negedge clk);
        cyc++;
        cke = cke_next;
        if (z_rom_avalid || z_sram_avalid) z_req++;
        if (!z_cpu_reset && z_fall < 0) z_fall = cyc;
        if (prev_rom_hold) begin
            chk("rom_avalid_held", rom_avalid, 1);
            chk("rom_addr_stable", rom_addr, prev_rom_addr);
        end
        if (prev_sram_hold) begin
            chk("sram_avalid_held", sram_avalid, 1);
            chk("sram_addr_stable", sram_addr, prev_sram_addr);
            chk("sram_wdata_stable", sram_wdata, prev_sram_data);
        end
        if (!cke) begin
            rom_ready = 0; rom_rvalid = 0; sram_ready = 0;
            return;
        end
        rom_rvalid = 0;
        if (rv_pend) begin
            rv_left--;
            if (rv_left == 0) begin
                rom_rvalid = 1;
                rom_rdata  = image[rv_idx];
                rv_pend    = 0;
                exp_q.push_back('{addr: 16'(rv_idx * 4), data: image[rv_idx]});
            end
        end
        rom_ready = 0;
        if (rom_avalid) begin
            if (!rom_wait) begin
                rom_stall = $urandom_range(0, max_stall);
                rom_wait  = 1;
            end
            rom_ready = (rom_stall == 0);
            if (rom_stall > 0) rom_stall--;
        end
        if (rom_avalid && rom_ready) begin
            chk("rom_addr", rom_addr, 64'(rd_idx * 4));
            rom_wait = 0; rv_pend = 1; rv_left = rv_delay;
            rv_idx = (rd_idx < NW) ? rd_idx : NW - 1;
            rd_idx++;
        end
        prev_rom_hold = rom_avalid && !rom_ready;
        prev_rom_addr = rom_addr;
        sram_ready = 0;
        if (sram_avalid) begin
            if (!sram_wait) begin
                sram_stall = $urandom_range(0, max_stall);
                sram_wait  = 1;
            end
            sram_ready = (sram_stall == 0);
            if (sram_stall > 0) sram_stall--;
        end
        if (sram_avalid && sram_ready) begin
            sram_wait = 0;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sram_extra_write: observed write to %0h, expected none", sram_addr);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sram_addr", sram_addr, e.addr);
                chk("sram_wdata", sram_wdata, e.data);
                chk("sram_wstrb", sram_wstrb, 4'hf);
            end
            idx = int'(sram_addr >> 2);
            if (idx < NW) mem[idx] = sram_wdata;
            writes++;
        end
        prev_sram_hold = sram_avalid && !sram_ready;
        prev_sram_addr = sram_addr;
        prev_sram_data = sram_wdata;
    endtask

    task automatic run_until_done(input int budget);
        while (cpu_reset && cyc < budget) step();
        n_cmp++;
        assert (!cpu_reset) else begin
            n_fail++;
            $error("FAIL release_timeout: observed cpu_reset %0b after %0d cycles, expected 0",
                   cpu_reset, cyc);
        end
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < NW; i++) chk($sformatf("%s_mem%0d", tag, i), mem[i], image[i]);
        chk({tag, "_writes"}, writes, NW);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic pulse_restart();
        restart = 1;
        step();
        restart = 0;
        cyc = 0;
        reset_models();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rom_avalid"}, rom_avalid, 0);
        chk({tag, "_sram_avalid"}, sram_avalid, 0);
    endtask

    initial begin
        logic       s_rav, s_sav, s_busy;
        logic [11:0] s_raddr;
        logic [15:0] s_saddr;
        bit         hit;
        arst_n = 0; cke = 1; restart = 0;
        rom_ready = 0; rom_rvalid = 0; rom_rdata = 0; sram_ready = 0;
        z_req = 0; cyc = 0;
        reset_models();
        #12;
        check_reset_outputs("rst");
        chk("rst_z_cpu_reset", z_cpu_reset, 1);

        // Default flow plus zero-word image in parallel.
        @(negedge clk);
        arst_n = 1;
        cyc = 0;
        step();
        chk("first_busy", busy, 1);
        chk("first_rom_avalid", rom_avalid, 1);
        run_until_done(200);
        chk("fall_cycle", cyc, 18);
        check_image("dflt");
        chk("zero_fall_cycle", z_fall, 1 + HOLD);
        chk("zero_no_requests", z_req, 0);
        chk("zero_done", z_done, 1);

        // Restart from RUN repeats the full sequence with identical timing.
        pulse_restart();
        chk("restart_cpu_reset", cpu_reset, 1);
        chk("restart_done", done, 0);
        run_until_done(200);
        chk("restart_fall_cycle", cyc, 18);
        check_image("rst1");

        // Backpressure with a restart pulse in the middle of the copy.
        max_stall = 7; rv_delay = 3;
        pulse_restart();
        repeat (6) step();
        restart = 1;
        repeat (3) step();
        restart = 0;
        chk("midcopy_restart_busy", busy, 1);
        chk("midcopy_restart_cpu_reset", cpu_reset, 1);
        run_until_done(1000);
        check_image("bp");

        // Clock enable low for 10 cycles mid-copy.
        max_stall = 0; rv_delay = 1;
        pulse_restart();
        repeat (7) step();
        cke_next = 0;
        step();
        s_rav = rom_avalid; s_sav = sram_avalid; s_busy = busy;
        s_raddr = rom_addr; s_saddr = sram_addr;
        repeat (9) step();
        chk("frz_rom_avalid", rom_avalid, s_rav);
        chk("frz_sram_avalid", sram_avalid, s_sav);
        chk("frz_rom_addr", rom_addr, s_raddr);
        chk("frz_sram_addr", sram_addr, s_saddr);
        chk("frz_busy", busy, s_busy);
        cke_next = 1;
        run_until_done(300);
        chk("frz_fall_cycle", cyc, 28);
        check_image("frz");

        // Asynchronous reset in the write of word 2, then a clean full copy.
        pulse_restart();
        hit = 0;
        while (!hit && cyc < 100) begin
            step();
            hit = sram_avalid && (sram_addr == 16'h8);
        end
        chk("reach_word2_write", hit, 1);
        #2;
        arst_n = 0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        arst_n = 1;
        cyc = 0;
        reset_models();
        run_until_done(200);
        chk("rerun_fall_cycle", cyc, 18);
        check_image("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
